data_memory_arbiter: RTL and testbench

Shares the single-port data RAM between the pipeline's MEM stage and an external debug/loader port.
- The CPU is served combinationally with zero added latency whenever it accesses memory.
- Debug requests use idle memory cycles.
- A starvation counter forces a one-cycle debug slot, stalling the pipeline, after MAX_WAIT consecutive lost cycles.
- The block sits between the MEM-stage control/address wires and the data RAM; its stall output feeds the hazard logic.

---
 rtl/data_memory_arbiter_if.sv | 46 ++++
 rtl/data_memory_arbiter.sv | 133 +++++++++++++
 tb/tb_data_memory_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the MEM stage, debug/loader port, data RAM and the arbiter.
// The arbiter takes the slave view; the surrounding pipeline/RAM take the master view.
interface data_memory_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  cpu_mem_read_i;
    logic                  cpu_mem_write_i;
    logic [ADDR_WIDTH-1:0] cpu_address_i;
    logic [DATA_WIDTH-1:0] cpu_write_data_i;
    logic [DATA_WIDTH-1:0] cpu_read_data_o;
    logic                  cpu_stall_o;

    logic                  dbg_req_i;
    logic                  dbg_we_i;
    logic [ADDR_WIDTH-1:0] dbg_address_i;
    logic [DATA_WIDTH-1:0] dbg_write_data_i;
    logic                  dbg_ready_o;
    logic                  dbg_done_o;
    logic [DATA_WIDTH-1:0] dbg_read_data_o;
    logic [15:0]           conflict_count_o;

    logic                  mem_read_o;
    logic                  mem_write_o;
    logic [ADDR_WIDTH-1:0] mem_address_o;
    logic [DATA_WIDTH-1:0] mem_write_data_o;
    logic [DATA_WIDTH-1:0] mem_data_i;

    modport slave (
        input  cpu_mem_read_i, cpu_mem_write_i, cpu_address_i, cpu_write_data_i,
        input  dbg_req_i, dbg_we_i, dbg_address_i, dbg_write_data_i,
        input  mem_data_i,
        output cpu_read_data_o, cpu_stall_o,
        output dbg_ready_o, dbg_done_o, dbg_read_data_o, conflict_count_o,
        output mem_read_o, mem_write_o, mem_address_o, mem_write_data_o
    );

    modport master (
        output cpu_mem_read_i, cpu_mem_write_i, cpu_address_i, cpu_write_data_i,
        output dbg_req_i, dbg_we_i, dbg_address_i, dbg_write_data_i,
        output mem_data_i,
        input  cpu_read_data_o, cpu_stall_o,
        input  dbg_ready_o, dbg_done_o, dbg_read_data_o, conflict_count_o,
        input  mem_read_o, mem_write_o, mem_address_o, mem_write_data_o
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Single-port data RAM arbiter: MEM stage has combinational priority, debug port
// uses idle cycles and gets a forced one-cycle slot after MAX_WAIT denied cycles.
module data_memory_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned MAX_WAIT    = 4,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    data_memory_arbiter_if.slave bus
);
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("MAX_WAIT must be in 1..15");
    end
    if (COUNT_WIDTH < 1 || COUNT_WIDTH > 16) begin : g_bad_count_width
        $error("COUNT_WIDTH must be in 1..16");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FORCE
    } state_t;

    state_t                 state, state_next;
    logic [3:0]             wait_cnt, wait_cnt_next;
    logic                   cpu_access;
    logic                   cpu_grant;
    logic                   dbg_grant;
    logic                   dbg_denied;
    logic [ADDR_WIDTH-1:0]  mem_address;
    logic [DATA_WIDTH-1:0]  mem_write_data;
    logic [DATA_WIDTH-1:0]  dbg_read_data;
    logic                   dbg_done;
    logic [COUNT_WIDTH-1:0] conflict_cnt;

    // Ownership: a forced slot beats the CPU, but if the request was withdrawn the
    // CPU keeps the RAM so its access is not silently dropped without a stall.
    always_comb begin
        cpu_access      = bus.cpu_mem_read_i | bus.cpu_mem_write_i;
        cpu_grant       = 1'b0;
        dbg_grant       = 1'b0;
        bus.cpu_stall_o = 1'b0;
        if (state == FORCE) begin
            if (bus.dbg_req_i) begin
                dbg_grant       = 1'b1;
                bus.cpu_stall_o = cpu_access;
            end else begin
                cpu_grant = cpu_access;
            end
        end else if (cpu_access) begin
            cpu_grant = 1'b1;
        end else if (bus.dbg_req_i) begin
            dbg_grant = 1'b1;
        end
        dbg_denied = bus.dbg_req_i & ~dbg_grant;
    end

    always_comb begin
        bus.mem_read_o      = 1'b0;
        bus.mem_write_o     = 1'b0;
        mem_address         = '0;
        mem_write_data      = '0;
        bus.cpu_read_data_o = '0;
        bus.dbg_ready_o     = dbg_grant;
        if (cpu_grant) begin
            bus.mem_read_o      = bus.cpu_mem_read_i;
            bus.mem_write_o     = bus.cpu_mem_write_i;
            mem_address         = bus.cpu_address_i;
            mem_write_data      = bus.cpu_write_data_i;
            bus.cpu_read_data_o = bus.mem_data_i;
        end else if (dbg_grant) begin
            bus.mem_read_o  = ~bus.dbg_we_i;
            bus.mem_write_o = bus.dbg_we_i;
            mem_address     = bus.dbg_address_i;
            mem_write_data  = bus.dbg_write_data_i;
        end
    end

    assign bus.mem_address_o    = mem_address;
    assign bus.mem_write_data_o = mem_write_data;

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        if (state == FORCE) begin
            state_next    = IDLE;
            wait_cnt_next = '0;
        end else if (!dbg_denied) begin
            state_next    = IDLE;
            wait_cnt_next = '0;
        end else begin
            state_next    = (wait_cnt == 4'(MAX_WAIT - 1)) ? FORCE : WAIT;
            wait_cnt_next = wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Forced slots are counted when actually used, so a withdrawn request is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_read_data <= '0;
            dbg_done      <= 1'b0;
            conflict_cnt  <= '0;
        end else begin
            dbg_done <= dbg_grant;
            if (dbg_grant && !bus.dbg_we_i) begin
                dbg_read_data <= bus.mem_data_i;
            end
            if (state == FORCE && bus.dbg_req_i && conflict_cnt != '1) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

    assign bus.dbg_read_data_o = dbg_read_data;
    assign bus.dbg_done_o      = dbg_done;

    always_comb begin
        bus.conflict_count_o                  = '0;
        bus.conflict_count_o[COUNT_WIDTH-1:0] = conflict_cnt;
    end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: per-cycle vector table plus hand sequences
// for withdrawal, reset during a forced slot and counter saturation (narrow counter copy).
module tb_data_memory_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_memory_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();
    data_memory_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus2 ();

    data_memory_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .MAX_WAIT(4), .COUNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    data_memory_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .MAX_WAIT(1), .COUNT_WIDTH(3)
    ) dut_sat (
        .clk(clk), .reset(reset), .bus(bus2.slave)
    );

    logic [31:0] ram [256];
    assign bus.mem_data_i  = ram[bus.mem_address_o];
    assign bus2.mem_data_i = 32'h0;
    always @(posedge clk) begin
        if (bus.mem_write_o) ram[bus.mem_address_o] <= bus.mem_write_data_o;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic req, input logic we, input logic [7:0] daddr, input logic [31:0] dwdata);
        bus.cpu_mem_read_i   = rd;
        bus.cpu_mem_write_i  = wr;
        bus.cpu_address_i    = addr;
        bus.cpu_write_data_i = wdata;
        bus.dbg_req_i        = req;
        bus.dbg_we_i         = we;
        bus.dbg_address_i    = daddr;
        bus.dbg_write_data_i = dwdata;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        req;
        logic        we;
        logic [7:0]  daddr;
        logic [31:0] dwdata;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        stall;
        logic        ready;
        logic        done;
        logic [31:0] drd;
        logic [15:0] cnt;
        logic        mrd;
        logic        mwr;
    } vec_t;

    vec_t vecs [16];

    initial begin
        // rd wr addr wdata | req we daddr dwdata | chk rdata stall ready done drd cnt mrd mwr
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,
                     1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        16'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h10, 32'hCAFE0001, 1'b0, 1'b0, 8'h00, 32'h0,
                     1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        16'd0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 8'h10, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,
                     1'b1, 32'hCAFE0001, 1'b0, 1'b0, 1'b0, 32'h0,        16'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 8'h20, 32'h12345678,
                     1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        16'd0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 8'h20, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,
                     1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 32'h0,        16'd0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 8'h10, 32'h0,
                     1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        16'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,
                     1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 32'hCAFE0001, 16'd0, 1'b0, 1'b0};
        for (int unsigned i = 7; i <= 10; i++) begin
            vecs[i] = '{1'b1, 1'b0, 8'h10, 32'h0,     1'b1, 1'b0, 8'h20, 32'h0,
                        1'b1, 32'hCAFE0001, 1'b0, 1'b0, 1'b0, 32'hCAFE0001, 16'd0, 1'b1, 1'b0};
        end
        vecs[11] = '{1'b1, 1'b0, 8'h10, 32'h0,        1'b1, 1'b0, 8'h20, 32'h0,
                     1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 32'hCAFE0001, 16'd0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 8'h10, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,
                     1'b1, 32'hCAFE0001, 1'b0, 1'b0, 1'b1, 32'h12345678, 16'd1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 8'h30, 32'hDEADBEEF,
                     1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 32'h12345678, 16'd1, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,
                     1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678, 16'd1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 8'h30, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,
                     1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h12345678, 16'd1, 1'b1, 1'b0};

        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        bus2.cpu_mem_read_i   = 1'b0;
        bus2.cpu_mem_write_i  = 1'b0;
        bus2.cpu_address_i    = 8'h00;
        bus2.cpu_write_data_i = 32'h0;
        bus2.dbg_req_i        = 1'b0;
        bus2.dbg_we_i         = 1'b0;
        bus2.dbg_address_i    = 8'h00;
        bus2.dbg_write_data_i = 32'h0;

        // Reset state
        #3;
        check("reset stall", 32'(bus.cpu_stall_o), 32'd0);
        check("reset ready", 32'(bus.dbg_ready_o), 32'd0);
        check("reset done", 32'(bus.dbg_done_o), 32'd0);
        check("reset dbg_rdata", bus.dbg_read_data_o, 32'h0);
        check("reset count", 32'(bus.conflict_count_o), 32'd0);
        check("reset mem_rd", 32'(bus.mem_read_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Table-driven cycles
        for (int unsigned i = 0; i < 16; i++) begin
            cyc();
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                  vecs[i].req, vecs[i].we, vecs[i].daddr, vecs[i].dwdata);
            #3;
            if (vecs[i].chk_rd) check($sformatf("v%0d cpu_rdata", i), bus.cpu_read_data_o, vecs[i].rdata);
            check($sformatf("v%0d stall", i), 32'(bus.cpu_stall_o), 32'(vecs[i].stall));
            check($sformatf("v%0d ready", i), 32'(bus.dbg_ready_o), 32'(vecs[i].ready));
            check($sformatf("v%0d done", i), 32'(bus.dbg_done_o), 32'(vecs[i].done));
            check($sformatf("v%0d dbg_rdata", i), bus.dbg_read_data_o, vecs[i].drd);
            check($sformatf("v%0d count", i), 32'(bus.conflict_count_o), 32'(vecs[i].cnt));
            check($sformatf("v%0d mem_rd", i), 32'(bus.mem_read_o), 32'(vecs[i].mrd));
            check($sformatf("v%0d mem_wr", i), 32'(bus.mem_write_o), 32'(vecs[i].mwr));
        end

        // Withdrawn request during FORCE
        for (int unsigned k = 0; k < 4; k++) begin
            cyc();
            drive(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0);
            #3;
            check($sformatf("wd deny%0d ready", k), 32'(bus.dbg_ready_o), 32'd0);
        end
        cyc();
        drive(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h20, 32'h0);
        #3;
        check("wd force stall", 32'(bus.cpu_stall_o), 32'd0);
        check("wd force ready", 32'(bus.dbg_ready_o), 32'd0);
        check("wd force mem_wr", 32'(bus.mem_write_o), 32'd0);
        cyc();
        #3;
        check("wd after count", 32'(bus.conflict_count_o), 32'd1);
        check("wd after done", 32'(bus.dbg_done_o), 32'd0);

        // Back in IDLE with wait_cnt cleared: FORCE again after exactly 4 denied cycles
        for (int unsigned k = 0; k < 4; k++) begin
            cyc();
            drive(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b1, 8'h10, 32'h0BADF00D);
            #3;
            check($sformatf("rst deny%0d ready", k), 32'(bus.dbg_ready_o), 32'd0);
            check($sformatf("rst deny%0d stall", k), 32'(bus.cpu_stall_o), 32'd0);
        end
        cyc();
        #3;
        check("rst force stall", 32'(bus.cpu_stall_o), 32'd1);
        check("rst force ready", 32'(bus.dbg_ready_o), 32'd1);
        check("rst force mem_wr", 32'(bus.mem_write_o), 32'd1);
        check("rst force count", 32'(bus.conflict_count_o), 32'd1);
        // Reset asserted in the middle of the forced write
        #1 reset = 1'b1;
        #1;
        check("rst mid stall", 32'(bus.cpu_stall_o), 32'd0);
        check("rst mid ready", 32'(bus.dbg_ready_o), 32'd0);
        check("rst mid mem_wr", 32'(bus.mem_write_o), 32'd0);
        check("rst mid count", 32'(bus.conflict_count_o), 32'd0);
        check("rst mid dbg_rdata", bus.dbg_read_data_o, 32'h0);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        check("rst held done", 32'(bus.dbg_done_o), 32'd0);
        cyc();
        reset = 1'b0;
        #3;
        check("rst rel done", 32'(bus.dbg_done_o), 32'd0);
        cyc();
        drive(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        #3;
        check("rst ram unchanged", bus.cpu_read_data_o, 32'hCAFE0001);
        check("rst post done", 32'(bus.dbg_done_o), 32'd0);
        check("rst post count", 32'(bus.conflict_count_o), 32'd0);

        // Saturation on the narrow-counter copy (MAX_WAIT=1, 3-bit counter)
        cyc();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        bus2.cpu_mem_read_i = 1'b1;
        bus2.dbg_req_i      = 1'b1;
        #3;
        check("sat c0 stall", 32'(bus2.cpu_stall_o), 32'd0);
        check("sat c0 ready", 32'(bus2.dbg_ready_o), 32'd0);
        cyc();
        #3;
        check("sat c1 stall", 32'(bus2.cpu_stall_o), 32'd1);
        check("sat c1 ready", 32'(bus2.dbg_ready_o), 32'd1);
        repeat (4) cyc();
        cyc();
        #3;
        check("sat c6 count", 32'(bus2.conflict_count_o), 32'd3);
        repeat (19) cyc();
        cyc();
        #3;
        check("sat full count", 32'(bus2.conflict_count_o), 32'd7);
        for (int unsigned k = 0; k < 3; k++) begin
            cyc();
            #3;
            check($sformatf("sat hold%0d count", k), 32'(bus2.conflict_count_o), 32'd7);
        end
        bus2.cpu_mem_read_i = 1'b0;
        bus2.dbg_req_i      = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
